// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared constants for the general-purpose register file
// Holds register count, address width, special register indices and the
// architectural reset values of the global and stack pointers.
package reg_bank_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;

  localparam int REG_ZERO = 0;
  localparam int REG_GP   = 28;
  localparam int REG_SP   = 29;

  localparam logic [31:0] GP_RESET_DEFAULT = 32'h1000_8000;
  localparam logic [31:0] SP_RESET_DEFAULT = 32'h7FFF_EFFC;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]   reg_mask_t;

  // One-hot select for a register index.
  function automatic reg_mask_t reg_onehot(input reg_addr_t idx);
    reg_onehot = reg_mask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/register_cell.sv
// rtl/register_cell.sv - one N-bit register with load enable and async reset
// Ports:
//   clk   in  1  rising-edge clock
//   reset in  1  asynchronous active-high reset, loads RESET_VALUE
//   en    in  1  load enable
//   d     in  N  data to load
//   q     out N  stored value
module register_cell #(
  parameter int          N           = 32,
  parameter logic [N-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_bank.sv
// rtl/register_bank.sv - storage stage of the 32-entry register file
// Build option: REG_ZERO_HARDWIRED_EN makes register 0 a constant zero with
// no flop; writes to index 0 are dropped and Written[0] stays 0.
// Ports:
//   clk            in  1       rising-edge clock
//   reset          in  1       asynchronous active-high reset
//   Reg_Write      in  1       write enable
//   Write_Register in  5       index of register to write
//   Write_Data     in  N       data to write
//   Q              out 32*N    all registers flattened, reg i at Q[i*N +: N]
//   Written        out 32      sticky per-register "written since reset" flags
module register_bank
  import reg_bank_pkg::*;
#(
  parameter int          N        = 32,
  parameter logic [31:0] GP_RESET = GP_RESET_DEFAULT,
  parameter logic [31:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write,
  input  logic [REG_ADDR_W-1:0] Write_Register,
  input  logic [N-1:0]          Write_Data,
  output logic [NUM_REGS*N-1:0] Q,
  output logic [NUM_REGS-1:0]   Written
);

`ifdef REG_ZERO_HARDWIRED_EN
  localparam bit ZERO_HARDWIRED = 1'b1;
`else
  localparam bit ZERO_HARDWIRED = 1'b0;
`endif

  // Size casts truncate the 32-bit reset constants to the register width.
  localparam logic [N-1:0] GP_RST = N'(GP_RESET);
  localparam logic [N-1:0] SP_RST = N'(SP_RESET);

  // Index 0 is masked out of the decode when it is hardwired so neither a
  // data flop nor its flag can ever respond to a write there.
  localparam reg_mask_t DECODE_MASK = ZERO_HARDWIRED ? ~reg_mask_t'(1) : '1;

  reg_mask_t write_en;

  always_comb begin
    write_en = '0;
    if (Reg_Write) begin
      write_en = reg_onehot(Write_Register) & DECODE_MASK;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [N-1:0] RST_VAL = (i == REG_GP) ? GP_RST :
                                       (i == REG_SP) ? SP_RST : '0;
    if (ZERO_HARDWIRED && (i == REG_ZERO)) begin : g_zero
      assign Q[i*N +: N] = '0;
    end else begin : g_cell
      register_cell #(
        .N           (N),
        .RESET_VALUE (RST_VAL)
      ) u_cell (
        .clk   (clk),
        .reset (reset),
        .en    (write_en[i]),
        .d     (Write_Data),
        .q     (Q[i*N +: N])
      );
    end
  end

  // Flags only ever set; reset is the sole way to clear them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Written <= '0;
    end else begin
      Written <= Written | write_en;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - directed self-checking bench for register_bank
module tb_register_bank;
  import reg_bank_pkg::*;

  localparam int N = 32;

  logic              clk;
  logic              clk_run;
  logic              reset;
  logic              Reg_Write;
  logic [4:0]        Write_Register;
  logic [N-1:0]      Write_Data;
  logic [32*N-1:0]   Q;
  logic [31:0]       Written;

  int errors;
  int checks;

  logic [31:0] m_reg [32];
  logic [31:0] m_written;

`ifdef REG_ZERO_HARDWIRED_EN
  localparam bit ZERO_HW = 1'b1;
`else
  localparam bit ZERO_HW = 1'b0;
`endif

  register_bank #(.N(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .Reg_Write      (Reg_Write),
    .Write_Register (Write_Register),
    .Write_Data     (Write_Data),
    .Q              (Q),
    .Written        (Written)
  );

  initial clk = 1'b0;
  always #5 if (clk_run) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_reg[28] = 32'h1000_8000;
    m_reg[29] = 32'h7FFF_EFFC;
    m_written = 32'h0;
  endtask

  task automatic model_write(input int idx, input logic [31:0] data);
    if (!(ZERO_HW && idx == 0)) begin
      m_reg[idx] = data;
      m_written[idx] = 1'b1;
    end
  endtask

  task automatic check_all(input string phase);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_q%0d", phase, i), Q[i*N +: N], m_reg[i]);
    check($sformatf("%s_written", phase), Written, m_written);
  endtask

  // Present a write after a falling edge; it lands on the next rising edge.
  task automatic drive(input logic we, input int idx, input logic [31:0] data);
    @(negedge clk);
    Reg_Write      = we;
    Write_Register = 5'(idx);
    Write_Data     = data;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk_run = 1'b0;
    reset = 1'b0;
    Reg_Write = 1'b0;
    Write_Register = 5'd0;
    Write_Data = '0;

    // Reset with the clock stopped: values must appear without any edge.
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_all("reset");

    clk_run = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Single write.
    drive(1'b1, 5, 32'hDEAD_BEEF);
    model_write(5, 32'hDEAD_BEEF);
    @(negedge clk);
    Reg_Write = 1'b0;
    check_all("single");
    check("single_written_const", Written, 32'h0000_0020);

    // Write disabled for three edges.
    drive(1'b0, 7, 32'h1234_5678);
    repeat (3) @(negedge clk);
    check_all("disabled");

    // Index 0.
    drive(1'b1, 0, 32'hFFFF_FFFF);
    model_write(0, 32'hFFFF_FFFF);
    @(negedge clk);
    Reg_Write = 1'b0;
    check("reg0_q", Q[0 +: N], ZERO_HW ? 32'h0 : 32'hFFFF_FFFF);
    check("reg0_flag", {31'h0, Written[0]}, ZERO_HW ? 32'h0 : 32'h1);

    // Sweep 1..31 on consecutive edges.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, i, 32'(i) * 32'h0101_0101);
      model_write(i, 32'(i) * 32'h0101_0101);
    end
    @(negedge clk);
    Reg_Write = 1'b0;
    check_all("sweep");
    check("sweep_written_const", Written, ZERO_HW ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);

    // Async reset between edges with a write held active.
    @(negedge clk);
    Reg_Write      = 1'b1;
    Write_Register = 5'd3;
    Write_Data     = 32'hAAAA_5555;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("midreset");
    @(posedge clk);
    #1;
    check_all("reset_held");

    // First edge after release honours the held write.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    Reg_Write = 1'b0;
    model_write(3, 32'hAAAA_5555);
    check_all("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
